// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 32-bit memory port: fetch (0) vs load/store (1).
// Registers the winner's command, runs a valid/ready handshake, aborts with err after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        sel,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } cmd_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_n;
  logic            last;
  logic            winner;
  logic            grant;
  logic            tie;
  logic            expire;
  logic [7:0]      cnt;
  logic [1:0]      req;
  cmd_t [1:0]      cmd;

  assign req    = {req1, req0};
  assign cmd[0] = {addr0, wdata0, we0};
  assign cmd[1] = {addr1, wdata1, we1};

  always_comb begin
    state_n = state;
    winner  = sel;
    grant   = 1'b0;
    tie     = &req;
    expire  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant   = 1'b1;
          winner  = tie ? ~last : req[1];
          state_n = BUSY;
        end
      end
      BUSY: begin
        // a ready on the last allowed cycle completes normally, not as a timeout
        expire = !mem_ready && (cnt == CNT_LAST);
        if (mem_ready || expire) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      // strobes are decoded from next state so every output stays a flop
      mem_valid <= (state_n == BUSY);
      done0     <= (state_n == DONE) && !sel;
      done1     <= (state_n == DONE) && sel;
      if (grant) begin
        sel                            <= winner;
        {mem_addr, mem_wdata, mem_we}  <= cmd[winner];
        cnt                            <= '0;
        if (tie) last <= winner;
      end
      if (state == BUSY) begin
        if (mem_ready) begin
          rdata <= mem_rdata;
          err   <= 1'b0;
        end else if (expire) begin
          rdata <= '0;
          err   <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): table of transactions plus reset/drop sequences.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        sel, mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic        done0, done1, err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .sel(sel), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err)
  );

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        w0, w1;
    int          delay;      // wait cycles before ready; >= TO means never
    logic [31:0] rd_in;
    logic        e_sel;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_cycles;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  // Waits (bounded) for mem_valid at a negedge; returns 1 if seen.
  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_valid) begin ok = 1; break; end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    int k;
    string tag;
    tag = $sformatf("v%0d", idx);
    req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1;
    wdata0 = v.wd0; wdata1 = v.wd1; we0 = v.w0; we1 = v.w1;
    mem_ready = 0; mem_rdata = v.rd_in;
    wait_valid(ok);
    chk({tag, " grant seen"}, 32'(ok), 32'd1);
    if (!ok) begin idle_inputs(); return; end
    chk({tag, " sel"},   32'(sel),   32'(v.e_sel));
    chk({tag, " addr"},  mem_addr,   v.e_addr);
    chk({tag, " wdata"}, mem_wdata,  v.e_wdata);
    chk({tag, " we"},    32'(mem_we), 32'(v.e_we));
    k = 0;
    while (mem_valid && k < 20) begin
      if (done0 || done1) chk({tag, " done during busy"}, 32'({done1, done0}), 32'd0);
      mem_ready = (k == v.delay);
      @(negedge clk);
      k++;
    end
    mem_ready = 0;
    chk({tag, " valid cycles"}, 32'(k), 32'(v.e_cycles));
    chk({tag, " done0"}, 32'(done0), 32'(!v.e_sel));
    chk({tag, " done1"}, 32'(done1), 32'(v.e_sel));
    chk({tag, " rdata"}, rdata, v.e_rdata);
    chk({tag, " err"},   32'(err), 32'(v.e_err));
    idle_inputs();
    @(negedge clk);
    chk({tag, " done cleared"}, 32'({done1, done0}), 32'd0);
  endtask

  initial begin
    bit ok;
    int k;

    //          r0 r1 a0          a1          wd0          wd1          w0 w1 dly rd_in        sel addr        wdata        we rdata        err cyc
    vecs[0]  = '{1, 0, 32'h40,     32'h0,      32'h0,       32'h0,       0, 0, 0,  32'hDEADBEEF, 0, 32'h40,     32'h0,       0, 32'hDEADBEEF, 0, 1};
    vecs[1]  = '{1, 1, 32'h200,    32'h300,    32'hA0A0A0A0, 32'hB1B1B1B1, 0, 1, 0, 32'h11111111, 0, 32'h200,    32'hA0A0A0A0, 0, 32'h11111111, 0, 1};
    vecs[2]  = '{1, 1, 32'h200,    32'h300,    32'hA0A0A0A0, 32'hB1B1B1B1, 0, 1, 0, 32'h22222222, 1, 32'h300,    32'hB1B1B1B1, 1, 32'h22222222, 0, 1};
    vecs[3]  = '{1, 1, 32'h204,    32'h304,    32'hA2A2A2A2, 32'hB3B3B3B3, 0, 1, 0, 32'h33333333, 0, 32'h204,    32'hA2A2A2A2, 0, 32'h33333333, 0, 1};
    vecs[4]  = '{1, 1, 32'h204,    32'h304,    32'hA2A2A2A2, 32'hB3B3B3B3, 0, 1, 0, 32'h44444444, 1, 32'h304,    32'hB3B3B3B3, 1, 32'h44444444, 0, 1};
    vecs[5]  = '{0, 1, 32'h0,      32'h100,    32'h0,       32'h12345678, 0, 1, 3, 32'h0000AAAA, 1, 32'h100,    32'h12345678, 1, 32'h0000AAAA, 0, 4};
    vecs[6]  = '{1, 0, 32'h80,     32'h0,      32'h0,       32'h0,       0, 0, 99, 32'hFFFFFFFF, 0, 32'h80,     32'h0,       0, 32'h0,        1, 4};
    vecs[7]  = '{0, 1, 32'h0,      32'h84,     32'h0,       32'h0,       0, 0, 3,  32'h00000055, 1, 32'h84,     32'h0,       0, 32'h00000055, 0, 4};
    vecs[8]  = '{1, 0, 32'hC0,     32'h0,      32'hCAFEF00D, 32'h0,       1, 0, 1,  32'h0,        0, 32'hC0,     32'hCAFEF00D, 1, 32'h0,        0, 2};
    vecs[9]  = '{1, 1, 32'h10,     32'h20,     32'h1,       32'h2,       0, 0, 2,  32'h0BADF00D, 0, 32'h10,     32'h1,       0, 32'h0BADF00D, 0, 3};
    vecs[10] = '{0, 1, 32'h0,      32'h24,     32'h0,       32'h0,       0, 0, 99, 32'h77777777, 1, 32'h24,     32'h0,       0, 32'h0,        1, 4};

    idle_inputs();
    rst_n = 0;
    #12;
    chk("reset mem_valid", 32'(mem_valid), 32'd0);
    chk("reset sel",       32'(sel),       32'd0);
    chk("reset addr",      mem_addr,       32'd0);
    chk("reset wdata",     mem_wdata,      32'd0);
    chk("reset done",      32'({done1, done0, mem_we, err}), 32'd0);
    chk("reset rdata",     rdata,          32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // reset in the 2nd wait cycle: outputs clear at once, no done, tie order restarts
    req1 = 1; addr1 = 32'h500; we1 = 1; wdata1 = 32'h5A5A5A5A;
    wait_valid(ok);
    chk("rst seq grant", 32'(ok), 32'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst mid valid", 32'(mem_valid), 32'd0);
    chk("rst mid addr",  mem_addr, 32'd0);
    chk("rst mid misc",  32'({sel, mem_we, done1, done0, err}), 32'd0);
    chk("rst mid wdata", mem_wdata, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done0 || done1 || mem_valid) k++;
    end
    chk("no done after rst", 32'(k), 32'd0);
    run_vec(100, '{1, 1, 32'h600, 32'h700, 32'h0, 32'h0, 0, 0, 0, 32'h13579BDF,
                   0, 32'h600, 32'h0, 0, 32'h13579BDF, 0, 1});

    // req0 dropped right after grant: still completes once, no regrant
    req0 = 1; addr0 = 32'h900; mem_rdata = 32'h2468ACE0;
    wait_valid(ok);
    chk("drop grant", 32'(ok), 32'd1);
    req0 = 0;
    k = 0;
    while (mem_valid && k < 20) begin
      mem_ready = (k == 1);
      @(negedge clk);
      k++;
    end
    mem_ready = 0;
    chk("drop valid cycles", 32'(k), 32'd2);
    chk("drop done0", 32'(done0), 32'd1);
    chk("drop rdata", rdata, 32'h2468ACE0);
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_valid || done0 || done1) k++;
    end
    chk("drop no regrant", 32'(k), 32'd0);
    chk("rdata held", rdata, 32'h2468ACE0);
    chk("sel held", 32'(sel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
